quadc_tx_pattern: RTL
=====================

Name: quadc_tx_pattern

Overview:
Transmit-side counterpart of the quad-ADC capture interface. Produces four 8-bit sample lanes, a valid flag and a periodic sync pulse in the user_clk domain. Lanes are sourced from a buffered 32-bit host stream or from built-in patterns. Used for loopback and bring-up of downstream PFB/FFT logic without live ADCs, and to drive DAC boards.

Parameters:
SYNC_PERIOD, 1024, output cycles between sync pulses in RUN (>=2).
FIFO_DEPTH, 16, stream FIFO depth in 32-bit words; power of 2, >=4.
PREFILL, 4, words required in FIFO before stream mode leaves ARM (1..FIFO_DEPTH).

Ports:
user_clk  in  1  sole clock; all logic rising-edge.
reset  in  1  asynchronous, active-high; clears all state.
enable  in  1  level; 1 = run, 0 = stop and flush.
mode  in  2  0 stream, 1 ramp, 2 constant, 3 PRBS/zero (see Optional Feature); sampled only in IDLE->ARM.
const_val  in  8  lane value for mode 2.
s_data  in  32  stream word; lane k = s_data[8k+7:8k].
s_valid  in  1  stream word present.
s_ready  out  1  FIFO can accept; a transfer occurs when s_valid & s_ready.
adc0_data  out  8  lane 0 sample.
adc1_data  out  8  lane 1 sample.
adc2_data  out  8  lane 2 sample.
adc3_data  out  8  lane 3 sample.
valid  out  1  lanes carry real samples this cycle.
sync  out  1  one-cycle frame marker.
underflow_cnt  out  16  stream-mode underflow cycles, saturating.

Behaviour:
- Reset: all lanes 0x00, valid 0, sync 0, s_ready 0, underflow_cnt 0, FIFO empty, state IDLE, ramp base 0, sync counter 0.
- All outputs registered. A word popped in cycle N appears on the lanes in cycle N+1.
- s_ready = (state != IDLE) & FIFO not full. While full there is no push, so a simultaneous push/pop at full cannot occur. Push and pop in the same cycle at any other level keeps the count unchanged.
- FSM IDLE: lanes 0x00, valid 0, FIFO held empty. enable=1 latches mode and moves to ARM.
- FSM ARM: lanes 0x00, valid 0. Moves to RUN when the latched mode != 0, or when FIFO count >= PREFILL. enable=0 returns to IDLE.
- FSM RUN: first RUN output cycle has sync=1. sync=1 again every SYNC_PERIOD cycles; the counter wraps to 0 at SYNC_PERIOD-1. enable=0 moves to IDLE on the next edge; FIFO flushed, underflow_cnt retained.
- Mode 0 (stream): pop one word per cycle when not empty → lanes = word, valid 1.
  - If empty: lanes 0x80 (midscale), valid 0, underflow_cnt +1, saturating at 0xFFFF.
  - sync cadence continues through underflow.
- Mode 1 (ramp): laneK = base+K mod 256, valid 1. base += 4 each RUN cycle and wraps 0xFC→0x00. base resets to 0 on ARM→RUN.
- Mode 2 (constant): all lanes = const_val, sampled live; valid 1.
- Mode 3: see Optional Feature.
- reset mid-RUN: immediate return to reset values, no partial sync.
- mode changes outside IDLE are ignored.

Optional Feature:
QUADC_TX_PRBS_EN:
- Defined: mode 3 = per-lane PRBS-7 (x^7+x^6+1), advanced 8 bits per cycle.
  - Lane k is seeded with 7'h01+k on ARM→RUN; lane output = next 8 generated bits, LSB first.
  - valid 1.
- Undefined: mode 3 outputs 0x00 on all lanes with valid 1. No LFSR logic is synthesised.

Test Plan:
1. Reset, enable=1, mode=1, SYNC_PERIOD=8 → first RUN cycle lanes 00/01/02/03 with sync=1; next cycle 04/05/06/07; sync again 8 cycles later; base wraps after 0xFC/FD/FE/FF to 00.
2. Mode 0, push 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C, then stall → RUN entered after the 4th word; lanes show 00..03, 04..07, 08..0B, 0C..0F with valid=1; then 0x80 with valid=0 and underflow_cnt counting 1, 2, 3…
3. Mode 0, hold s_valid=1 with no drain during ARM (PREFILL=16) → s_ready drops after 16 accepted words; no word lost or duplicated at output.
4. Mode 2, const_val=0x5A, then change const_val to 0xC3 mid-RUN → lanes follow 1 cycle later; change mode to 1 mid-RUN → no effect.
5. Assert reset asynchronously mid-RUN, then drop enable during RUN → outputs go 0 immediately with sync=0 on reset; enable=0 gives IDLE next edge, FIFO empty, s_ready=0, underflow_cnt retained.
6. With QUADC_TX_PRBS_EN, mode 3 → lane 0 matches the reference PRBS-7 from seed 0x01 over 127 cycles; without the macro → lanes 0x00, valid=1.

Source files
------------

// File: rtl/quadc_tx_pattern.sv
// Quad 8-bit lane generator: buffered host stream, ramp, constant or mode-3 pattern.
// Define QUADC_TX_PRBS_EN to build per-lane PRBS-7 for mode 3 (zeros otherwise).
module quadc_tx_pattern #(
    parameter int SYNC_PERIOD = 1024,
    parameter int FIFO_DEPTH  = 16,
    parameter int PREFILL     = 4
) (
    input  logic        user_clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [1:0]  mode,
    input  logic [7:0]  const_val,
    input  logic [31:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [7:0]  adc0_data,
    output logic [7:0]  adc1_data,
    output logic [7:0]  adc2_data,
    output logic [7:0]  adc3_data,
    output logic        valid,
    output logic        sync,
    output logic [15:0] underflow_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(SYNC_PERIOD);

    typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, RUN = 2'd2} state_t;

    state_t        state_q, state_d;
    logic [1:0]    mode_q;
    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;
    logic [31:0]   lanes_q, lanes_d;
    logic          valid_q, valid_d;
    logic          sync_q, sync_d;
    logic [7:0]    base_q, base_d;
    logic [SW-1:0] scnt_q, scnt_d;
    logic [15:0]   uf_q, uf_d;
    logic          full, empty, push, pop, run_en, flush;

    assign full    = cnt_q == CW'(FIFO_DEPTH);
    assign empty   = cnt_q == '0;
    assign s_ready = (state_q != IDLE) && !full;
    assign push    = s_valid && s_ready;
    assign run_en  = (state_q == RUN) && enable;
    assign pop     = run_en && (mode_q == 2'd0) && !empty;
    assign flush   = state_d == IDLE;

`ifdef QUADC_TX_PRBS_EN
    logic [6:0] lfsr_q [4];
    logic [6:0] lfsr_d [4];
    logic [6:0] pnext  [4];
    logic [7:0] pbyte  [4];

    // x^7+x^6+1, eight steps per cycle, first generated bit in the LSB
    function automatic logic [14:0] prbs8(input logic [6:0] s_in);
        logic [6:0] s;
        logic [7:0] b;
        s = s_in;
        b = '0;
        for (int i = 0; i < 8; i++) begin
            b[i] = s[6] ^ s[5];
            s    = {s[5:0], b[i]};
        end
        return {s, b};
    endfunction

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            {pnext[k], pbyte[k]} = prbs8(lfsr_q[k]);
        end
    end

    always_ff @(posedge user_clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 4; k++) lfsr_q[k] <= 7'(k + 1);
        end else begin
            for (int k = 0; k < 4; k++) lfsr_q[k] <= lfsr_d[k];
        end
    end
`endif

    always_ff @(posedge user_clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            mode_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && enable) mode_q <= mode;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (enable) state_d = ARM;
            ARM: begin
                if (!enable) state_d = IDLE;
                else if (mode_q != 2'd0 || cnt_q >= CW'(PREFILL)) state_d = RUN;
            end
            RUN:     if (!enable) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        lanes_d = '0;
        valid_d = 1'b0;
        sync_d  = 1'b0;
        base_d  = base_q;
        scnt_d  = scnt_q;
        uf_d    = uf_q;
`ifdef QUADC_TX_PRBS_EN
        for (int k = 0; k < 4; k++) lfsr_d[k] = lfsr_q[k];
`endif
        if (state_q == ARM) begin
            base_d = '0;
            scnt_d = '0;
`ifdef QUADC_TX_PRBS_EN
            for (int k = 0; k < 4; k++) lfsr_d[k] = 7'(k + 1);
`endif
        end
        if (run_en) begin
            sync_d  = scnt_q == '0;
            scnt_d  = (scnt_q == SW'(SYNC_PERIOD - 1)) ? '0 : scnt_q + 1'b1;
            valid_d = 1'b1;
            case (mode_q)
                2'd0: begin
                    if (!empty) begin
                        lanes_d = mem[rd_q];
                    end else begin
                        lanes_d = {4{8'h80}};
                        valid_d = 1'b0;
                        if (uf_q != 16'hFFFF) uf_d = uf_q + 1'b1;
                    end
                end
                2'd1: begin
                    lanes_d = {base_q + 8'd3, base_q + 8'd2,
                               base_q + 8'd1, base_q};
                    base_d  = base_q + 8'd4;
                end
                2'd2: lanes_d = {4{const_val}};
                default: begin
`ifdef QUADC_TX_PRBS_EN
                    lanes_d = {pbyte[3], pbyte[2], pbyte[1], pbyte[0]};
                    for (int k = 0; k < 4; k++) lfsr_d[k] = pnext[k];
`else
                    lanes_d = '0;
`endif
                end
            endcase
        end
    end

    always_ff @(posedge user_clk or posedge reset) begin
        if (reset) begin
            lanes_q <= '0;
            valid_q <= 1'b0;
            sync_q  <= 1'b0;
            base_q  <= '0;
            scnt_q  <= '0;
            uf_q    <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            lanes_q <= lanes_d;
            valid_q <= valid_d;
            sync_q  <= sync_d;
            base_q  <= base_d;
            scnt_q  <= scnt_d;
            uf_q    <= uf_d;
            if (flush) begin
                wr_q  <= '0;
                rd_q  <= '0;
                cnt_q <= '0;
            end else begin
                if (push) wr_q <= wr_q + 1'b1;
                if (pop) rd_q <= rd_q + 1'b1;
                if (push && !pop) cnt_q <= cnt_q + 1'b1;
                else if (pop && !push) cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge user_clk) begin
        if (push) mem[wr_q] <= s_data;
    end

    assign adc0_data     = lanes_q[7:0];
    assign adc1_data     = lanes_q[15:8];
    assign adc2_data     = lanes_q[23:16];
    assign adc3_data     = lanes_q[31:24];
    assign valid         = valid_q;
    assign sync          = sync_q;
    assign underflow_cnt = uf_q;
endmodule
